// File: rtl/cmp_pkg.sv
`default_nettype none
// ============================================================================
// cmp_pkg: state encoding and parameter helpers for chunked_magnitude_comparator
// Rev 1.0
// ============================================================================
package cmp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMP  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int calc_nchunk(input int width, input int chunk);
    return width / chunk;
  endfunction

  // Index must be at least one bit wide even when there is a single chunk
  function automatic int calc_idxw(input int nchunk);
    return (nchunk <= 2) ? 1 : $clog2(nchunk);
  endfunction

  function automatic bit chunk_ok(input int width, input int chunk);
    return (chunk >= 1) && (chunk <= width) && ((width % chunk) == 0);
  endfunction

endpackage
`default_nettype wire

// File: rtl/chunk_compare.sv
`default_nettype none
// ============================================================================
// chunk_compare: combinational CHUNK-bit unsigned compare with optional MSB flip
// Rev 1.0
// ============================================================================
module chunk_compare #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             flip_msb,
  output logic             gt,
  output logic             lt
);

  logic [CHUNK-1:0] a_adj;
  logic [CHUNK-1:0] b_adj;

  // Flipping the sign bit maps two's-complement order onto unsigned order
  always_comb begin
    a_adj            = a;
    b_adj            = b;
    a_adj[CHUNK-1]   = a[CHUNK-1] ^ flip_msb;
    b_adj[CHUNK-1]   = b[CHUNK-1] ^ flip_msb;
    gt               = (a_adj > b_adj);
    lt               = (a_adj < b_adj);
  end

endmodule
`default_nettype wire

// File: rtl/chunked_magnitude_comparator.sv
`default_nettype none
// ============================================================================
// chunked_magnitude_comparator: multi-cycle signed/unsigned compare, MSB chunk
// first. Define CMP_EARLY_EXIT_EN to finish on the first differing chunk.
// Rev 1.0
// ============================================================================
module chunked_magnitude_comparator #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             busy,
  output logic             done,
  output logic             a_gt_b,
  output logic             a_lt_b,
  output logic             a_eq_b
);

  import cmp_pkg::*;

  localparam int NCHUNK = calc_nchunk(WIDTH, CHUNK);
  localparam int IDXW   = calc_idxw(NCHUNK);
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCHUNK - 1);

`ifdef CMP_EARLY_EXIT_EN
  localparam bit EARLY_EXIT = 1'b1;
`else
  localparam bit EARLY_EXIT = 1'b0;
`endif

  generate
    if (!chunk_ok(WIDTH, CHUNK)) begin : g_bad_cfg
      $error("chunked_magnitude_comparator: WIDTH must be a multiple of CHUNK");
    end
  endgenerate

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_q, b_q;
  logic             smode_q;
  logic [IDXW-1:0]  idx;
  logic             decided, gt_q, lt_q;
  logic [CHUNK-1:0] chunk_a, chunk_b;
  logic             c_gt, c_lt;
  logic             hit, last_chunk, leave, accept;
  logic             res_gt, res_lt;

  always_comb begin
    chunk_a = '0;
    chunk_b = '0;
    for (int k = 0; k < NCHUNK; k++) begin
      if (idx == IDXW'(k)) begin
        chunk_a = a_q[WIDTH-1-k*CHUNK -: CHUNK];
        chunk_b = b_q[WIDTH-1-k*CHUNK -: CHUNK];
      end
    end
  end

  chunk_compare #(.CHUNK(CHUNK)) u_chunk_compare (
    .a        (chunk_a),
    .b        (chunk_b),
    .flip_msb (smode_q && (idx == '0)),
    .gt       (c_gt),
    .lt       (c_lt)
  );

  // Once decided, later chunks cannot alter the recorded outcome
  always_comb begin
    hit        = (c_gt | c_lt) && !decided;
    last_chunk = (idx == LAST_IDX);
    leave      = last_chunk || (EARLY_EXIT && hit);
    res_gt     = decided ? gt_q : c_gt;
    res_lt     = decided ? lt_q : c_lt;
    accept     = start && ((state == IDLE) || (state == DONE));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = CMP;
      CMP:     if (leave) state_nxt = DONE;
      DONE:    state_nxt = start ? CMP : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q     <= '0;
      b_q     <= '0;
      smode_q <= 1'b0;
      idx     <= '0;
      decided <= 1'b0;
      gt_q    <= 1'b0;
      lt_q    <= 1'b0;
      a_gt_b  <= 1'b0;
      a_lt_b  <= 1'b0;
      a_eq_b  <= 1'b0;
    end else if (accept) begin
      a_q     <= in_a;
      b_q     <= in_b;
      smode_q <= signed_mode;
      idx     <= '0;
      decided <= 1'b0;
      gt_q    <= 1'b0;
      lt_q    <= 1'b0;
    end else if (state == CMP) begin
      if (hit) begin
        decided <= 1'b1;
        gt_q    <= c_gt;
        lt_q    <= c_lt;
      end
      if (!last_chunk) idx <= idx + 1'b1;
      if (leave) begin
        a_gt_b <= res_gt;
        a_lt_b <= res_lt;
        a_eq_b <= ~(res_gt | res_lt);
      end
    end
  end

  assign busy = (state == CMP);
  assign done = (state == DONE);

endmodule
`default_nettype wire

// File: doc/chunked_magnitude_comparator.md
Name: chunked_magnitude_comparator

Overview:
- Parametrised multi-cycle magnitude comparator. Successor to the single-cycle 4-bit unsigned comparator.
- Compares two WIDTH-bit operands CHUNK bits per cycle, MSB chunk first.
- Supports a per-operation signed/unsigned mode and a start/busy/done handshake.
- Used where wide operands make a single-cycle compare too slow. Results are registered and held for downstream control logic.

Parameters:
WIDTH  16  operand width in bits; must be an integer multiple of CHUNK
CHUNK  4   bits compared per cycle; 1..WIDTH
(derived) NCHUNK = WIDTH/CHUNK, the number of compare cycles; IDXW = max(1, clog2(NCHUNK))

Ports:
clk          input   1      system clock, rising edge
rst          input   1      asynchronous reset, active-high
start        input   1      request a compare; sampled in IDLE or DONE
signed_mode  input   1      1 = two's-complement compare, 0 = unsigned; latched with start
in_a         input   WIDTH  operand A; latched with start
in_b         input   WIDTH  operand B; latched with start
busy         output  1      high while in CMP state
done         output  1      single-cycle pulse; results valid from this cycle on
a_gt_b       output  1      registered result A > B
a_lt_b       output  1      registered result A < B
a_eq_b       output  1      registered result A == B

Behaviour:
- Clocking and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values:
  - state = IDLE
  - busy, done, a_gt_b, a_lt_b, a_eq_b = 0
  - chunk index = 0; latched operands and mode = 0
- FSM states: IDLE, CMP, DONE.
- IDLE:
  - start=1 at an edge: latch in_a, in_b, signed_mode; idx <= 0; clear internal decided/gt/lt; go to CMP.
  - start=0: stay in IDLE.
- CMP (busy=1): each edge compares chunk idx, where idx 0 is bits [WIDTH-1 -: CHUNK].
  - Signed mode: on chunk 0 only, invert bit WIDTH-1 of both operands before the unsigned chunk compare (offset-binary trick).
  - First differing chunk sets decided=1 and records gt/lt. Later chunks never change an already-decided result.
  - The last chunk (idx = NCHUNK-1), or an early exit, moves to DONE.
  - At that same edge: a_gt_b <= gt, a_lt_b <= lt, a_eq_b <= ~(gt|lt). Exactly one flag is 1.
  - start is ignored while in CMP. Latched operands are immune to input changes.
- DONE: done=1 for exactly one cycle.
  - start=1: accepted as in IDLE and goes directly to CMP (back-to-back, no bubble).
  - start=0: go to IDLE.
- Result flags hold their value until the next DONE entry. They are not cleared on a new start.
- Latency, with start sampled at edge E0:
  - Full scan: done is high in the cycle after edge E_NCHUNK.
  - Early exit (see Optional Feature): done is high after edge E_(j+1), where j is the first differing chunk.
- CHUNK == WIDTH: NCHUNK=1, giving a single compare cycle.
- idx never wraps; it saturates at NCHUNK-1 before leaving CMP.
- rst asserted mid-compare: all outputs go to 0 immediately (asynchronously). The operation is discarded; no done pulse is produced.

Optional Feature:
- Macro: CMP_EARLY_EXIT_EN
- Defined: CMP leaves to DONE on the edge where the first differing chunk is detected. Latency is data-dependent, between 1 and NCHUNK cycles.
- Undefined: CMP always scans all NCHUNK chunks. Latency is constant at NCHUNK cycles; the result is frozen at the first difference.
- Flag values are identical in both builds; only timing differs.

Decomposition:
- Shared package cmp_pkg holds:
  - state encoding constants (IDLE/CMP/DONE, 2 bits)
  - NCHUNK/IDXW derivation function
  - WIDTH % CHUNK legality check, as an elaboration-time error
- One natural sub-module: chunk_compare. It is combinational, CHUNK-bit, with inputs a, b, flip_msb and outputs gt, lt. It is instantiated once and muxed by idx.

Test Plan (WIDTH=16, CHUNK=4):
1. Equal operands, unsigned: A=0x1234, B=0x1234 -> a_eq_b=1, gt=lt=0. done 4 cycles after start in both builds.
2. MSB difference: A=0x8000, B=0x7FFF.
   - unsigned -> a_gt_b=1; signed -> a_lt_b=1.
   - done after 1 cycle with CMP_EARLY_EXIT_EN, after 4 without.
3. LSB difference: A=0x1235, B=0x1234 unsigned -> a_gt_b=1, done after 4 cycles in both builds. Signed A=0xFFFF, B=0xFFFE -> a_gt_b=1.
4. Busy lockout: start with A=1, B=2, then pulse start with A=9, B=0 while busy=1 -> a_lt_b=1 (first op only), single done pulse.
5. Back-to-back: assert start in the DONE cycle with A=0x00FF, B=0x0100 -> immediate re-entry to CMP. Second done gives a_lt_b=1; flags hold the first result until then.
6. Reset mid-op: assert rst two cycles after start -> busy, done and all flags 0 without a clock edge. After release, no done pulse; a fresh start compares correctly.
